// File: rtl/nf10_arb_pkg.sv
// ============================================================================
//  Module   : nf10_arb_pkg
//  Purpose  : Shared definitions for the packet arbiters in front of the
//             AXI4-Stream width converters: FSM state encoding, the width of
//             the NetFPGA source-port field and the round-robin winner
//             function used by nf10_rr_pick.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package nf10_arb_pkg;

  // Width of the one-hot source-port (spt) field inside tuser.
  localparam int C_SPT_WIDTH = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Round-robin winner: first set bit of req at or after (last+1) mod n.
  // Candidates are walked from the furthest position back to the nearest so
  // the nearest requester after 'last' overwrites all others. Returns 'last'
  // when nothing requests (caller qualifies with |req).
  function automatic logic [2:0] next_rr(input logic [7:0] req,
                                         input logic [2:0] last,
                                         input int         n);
    logic [2:0] win;
    int         idx;
    win = last;
    for (int k = 8; k >= 1; k--) begin
      if (k <= n) begin
        idx = (int'(last) + k) % n;
        if (req[idx[2:0]]) begin
          win = idx[2:0];
        end
      end
    end
    return win;
  endfunction

endpackage

`default_nettype wire

// File: rtl/nf10_rr_pick.sv
// ============================================================================
//  Module   : nf10_rr_pick
//  Purpose  : Combinational round-robin priority picker. Chooses the first
//             requester at or after (last_i+1) mod C_NUM_INPUTS.
//  Ports    : req_i   - request vector, one bit per input
//             last_i  - index of the previous winner
//             grant_o - index of the winner (meaningful when valid_o=1)
//             valid_o - at least one request is present
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nf10_rr_pick
  import nf10_arb_pkg::*;
#(
  parameter int C_NUM_INPUTS = 4
) (
  input  logic [C_NUM_INPUTS-1:0] req_i,
  input  logic [2:0]              last_i,
  output logic [2:0]              grant_o,
  output logic                    valid_o
);

  // The package function works on a fixed 8-wide vector (max inputs).
  logic [7:0] req_pad;

  always_comb begin
    req_pad                    = '0;
    req_pad[C_NUM_INPUTS-1:0]  = req_i;
  end

  assign grant_o = next_rr(req_pad, last_i, C_NUM_INPUTS);
  assign valid_o = |req_i;

endmodule

`default_nettype wire

// File: rtl/nf10_axis_conv_arbiter.sv
// ============================================================================
//  Module   : nf10_axis_conv_arbiter
//  Purpose  : Packet-level round-robin arbiter sharing one 256->64 AXI4-Stream
//             width converter among C_NUM_INPUTS requesters. One input owns
//             the output for a whole packet (through tlast); a single
//             registered output stage drives the converter.
//  Ports    : axi_aclk / axi_reset      - clock, synchronous active-high reset
//             s_axis_*                  - packed requester streams, input i
//                                         occupies slice i of each bus
//             m_axis_*                  - registered stream to the converter
//             grant_idx                 - current owner (valid when busy=1)
//             busy                      - a packet is in progress
//  Config   : NF10_ARB_SPT_STAMP_EN - when defined, every forwarded beat gets
//             tuser[C_SPT_LSB+:8] = 8'h01 << (2*grant_idx) (zero for owners
//             above index 3); otherwise tuser passes through unchanged.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nf10_axis_conv_arbiter
  import nf10_arb_pkg::*;
#(
  parameter int C_NUM_INPUTS  = 4,
  parameter int C_DATA_WIDTH  = 256,
  parameter int C_TUSER_WIDTH = 128,
  parameter int C_SPT_LSB     = 16
) (
  input  logic                                    axi_aclk,
  input  logic                                    axi_reset,
  input  logic [C_NUM_INPUTS*C_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_NUM_INPUTS*C_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_NUM_INPUTS*C_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic [C_NUM_INPUTS-1:0]                 s_axis_tvalid,
  input  logic [C_NUM_INPUTS-1:0]                 s_axis_tlast,
  output logic [C_NUM_INPUTS-1:0]                 s_axis_tready,
  output logic [C_DATA_WIDTH-1:0]                 m_axis_tdata,
  output logic [C_DATA_WIDTH/8-1:0]               m_axis_tstrb,
  output logic [C_TUSER_WIDTH-1:0]                m_axis_tuser,
  output logic                                    m_axis_tvalid,
  output logic                                    m_axis_tlast,
  input  logic                                    m_axis_tready,
  output logic [2:0]                              grant_idx,
  output logic                                    busy
);

  localparam int C_STRB_WIDTH = C_DATA_WIDTH / 8;

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  arb_state_e                 state_q;
  logic [2:0]                 grant_q;
  logic [2:0]                 last_grant_q;
  logic                       busy_q;
  logic                       m_tvalid_q;
  logic                       m_tlast_q;
  logic [C_DATA_WIDTH-1:0]    m_tdata_q;
  logic [C_STRB_WIDTH-1:0]    m_tstrb_q;
  logic [C_TUSER_WIDTH-1:0]   m_tuser_q;

  // --------------------------------------------------------------------------
  // Input unpacking. Arrays are padded to 8 entries so the 3-bit grant index
  // addresses them without width games; padded slots never get selected.
  // --------------------------------------------------------------------------
  logic [C_DATA_WIDTH-1:0]  in_data [8];
  logic [C_STRB_WIDTH-1:0]  in_strb [8];
  logic [C_TUSER_WIDTH-1:0] in_user [8];
  logic [7:0]               in_valid;
  logic [7:0]               in_last;

  for (genvar i = 0; i < 8; i++) begin : g_unpack
    if (i < C_NUM_INPUTS) begin : g_used
      assign in_data[i]  = s_axis_tdata[i*C_DATA_WIDTH  +: C_DATA_WIDTH];
      assign in_strb[i]  = s_axis_tstrb[i*C_STRB_WIDTH  +: C_STRB_WIDTH];
      assign in_user[i]  = s_axis_tuser[i*C_TUSER_WIDTH +: C_TUSER_WIDTH];
      assign in_valid[i] = s_axis_tvalid[i];
      assign in_last[i]  = s_axis_tlast[i];
    end else begin : g_pad
      assign in_data[i]  = '0;
      assign in_strb[i]  = '0;
      assign in_user[i]  = '0;
      assign in_valid[i] = 1'b0;
      assign in_last[i]  = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Arbitration and handshake
  // --------------------------------------------------------------------------
  logic [2:0] pick_idx;
  logic       pick_valid;

  nf10_rr_pick #(
    .C_NUM_INPUTS (C_NUM_INPUTS)
  ) u_pick (
    .req_i   (s_axis_tvalid),
    .last_i  (last_grant_q),
    .grant_o (pick_idx),
    .valid_o (pick_valid)
  );

  // Output register can take a beat when empty or being drained this cycle.
  logic out_free;
  logic accept;

  assign out_free = !m_tvalid_q || m_axis_tready;
  assign accept   = (state_q == BUSY) && out_free && in_valid[grant_q];

  for (genvar i = 0; i < C_NUM_INPUTS; i++) begin : g_ready
    assign s_axis_tready[i] = (state_q == BUSY) && out_free && (grant_q == 3'(i));
  end

  // --------------------------------------------------------------------------
  // Next values for the output register
  // --------------------------------------------------------------------------
  logic [C_DATA_WIDTH-1:0]  data_d;
  logic [C_STRB_WIDTH-1:0]  strb_d;
  logic [C_TUSER_WIDTH-1:0] user_d;
  logic                     last_d;

  assign data_d = in_data[grant_q];
  assign strb_d = in_strb[grant_q];
  assign last_d = in_last[grant_q];

  always_comb begin
    user_d = in_user[grant_q];
`ifdef NF10_ARB_SPT_STAMP_EN
    // One-hot MAC-port encoding only exists for the first four ports.
    user_d[C_SPT_LSB +: C_SPT_WIDTH] = (grant_q < 3'd4)
                                       ? (8'h01 << {grant_q[1:0], 1'b0})
                                       : 8'h00;
`else
    // Source-port field forwarded untouched.
    user_d[C_SPT_LSB +: C_SPT_WIDTH] = in_user[grant_q][C_SPT_LSB +: C_SPT_WIDTH];
`endif
  end

  // --------------------------------------------------------------------------
  // FSM and output stage
  // --------------------------------------------------------------------------
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state_q      <= IDLE;
      grant_q      <= 3'd0;
      last_grant_q <= 3'(C_NUM_INPUTS - 1);
      busy_q       <= 1'b0;
      m_tvalid_q   <= 1'b0;
      m_tlast_q    <= 1'b0;
      m_tdata_q    <= '0;
      m_tstrb_q    <= '0;
      m_tuser_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            grant_q <= pick_idx;
            busy_q  <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          // Ownership is released only on an accepted tlast; the next
          // winner is chosen in the following IDLE cycle.
          if (accept && last_d) begin
            last_grant_q <= grant_q;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (accept) begin
        m_tvalid_q <= 1'b1;
        m_tlast_q  <= last_d;
        m_tdata_q  <= data_d;
        m_tstrb_q  <= strb_d;
        m_tuser_q  <= user_d;
      end else if (m_axis_tready) begin
        m_tvalid_q <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tstrb  = m_tstrb_q;
  assign m_axis_tuser  = m_tuser_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign grant_idx     = grant_q;
  assign busy          = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_nf10_axis_conv_arbiter.sv
// ============================================================================
//  Module   : tb_nf10_axis_conv_arbiter
//  Purpose  : Self-checking bench for nf10_axis_conv_arbiter. Packets are
//             generated per input; a packet-level round-robin model orders
//             them into an expected beat queue and grant list, and a monitor
//             compares everything the DUT emits against those queues.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nf10_axis_conv_arbiter;

  localparam int N    = 4;
  localparam int DW   = 256;
  localparam int UW   = 128;
  localparam int SW   = DW / 8;
  localparam int SPT  = 16;
  localparam int MAXB = 64;
  localparam int MAXP = 16;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  logic            clk;
  logic            rst;
  logic [N*DW-1:0] s_tdata;
  logic [N*SW-1:0] s_tstrb;
  logic [N*UW-1:0] s_tuser;
  logic [N-1:0]    s_tvalid;
  logic [N-1:0]    s_tlast;
  logic [N-1:0]    s_tready;
  logic [DW-1:0]   m_tdata;
  logic [SW-1:0]   m_tstrb;
  logic [UW-1:0]   m_tuser;
  logic            m_tvalid;
  logic            m_tlast;
  logic            m_tready;
  logic [2:0]      grant_idx;
  logic            busy;

  nf10_axis_conv_arbiter #(
    .C_NUM_INPUTS  (N),
    .C_DATA_WIDTH  (DW),
    .C_TUSER_WIDTH (UW),
    .C_SPT_LSB     (SPT)
  ) dut (
    .axi_aclk      (clk),
    .axi_reset     (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tstrb  (s_tstrb),
    .s_axis_tuser  (s_tuser),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tstrb  (m_tstrb),
    .m_axis_tuser  (m_tuser),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .grant_idx     (grant_idx),
    .busy          (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- storage
  beat_t stim [N][MAXB];
  int    nb  [N];
  int    ptr [N];
  int    np  [N];
  int    pk_start [N][MAXP];
  int    pk_len   [N][MAXP];
  beat_t exp_q [$];
  int    exp_g [$];

  int n_chk = 0;
  int n_err = 0;
  bit run_sb = 1'b0;
  int t_in  = -1;
  int t_out = -1;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Expected tuser as seen at the converter for a beat from input src.
  function automatic logic [UW-1:0] exp_user(input logic [UW-1:0] u, input int src);
    logic [UW-1:0] r;
    r = u;
`ifdef NF10_ARB_SPT_STAMP_EN
    r[SPT +: 8] = (src < 4) ? 8'(1 << (2 * src)) : 8'h00;
`else
    if (src < 0) r = '0;
`endif
    return r;
  endfunction

  // ---------------------------------------------------------------- stimulus generation
  // kind 0: input 0 alone, one 3-beat packet
  // kind 1: all inputs, two 2-beat packets each
  // kind 2: random packet counts (0..3) and lengths (1..5)
  // kind 3: input 2 alone, one 4-beat packet with tuser[23:16]=FF
  task automatic gen(input int kind);
    beat_t bt;
    int    npk;
    int    len;
    for (int i = 0; i < N; i++) begin
      np[i] = 0; nb[i] = 0; ptr[i] = 0;
      case (kind)
        0:       npk = (i == 0) ? 1 : 0;
        1:       npk = 2;
        3:       npk = (i == 2) ? 1 : 0;
        default: npk = $urandom_range(0, 3);
      endcase
      for (int p = 0; p < npk; p++) begin
        case (kind)
          0:       len = 3;
          1:       len = 2;
          3:       len = 4;
          default: len = $urandom_range(1, 5);
        endcase
        pk_start[i][p] = nb[i];
        pk_len[i][p]   = len;
        for (int b = 0; b < len; b++) begin
          for (int w = 0; w < DW / 32; w++) bt.d[w*32 +: 32] = $urandom;
          for (int w = 0; w < UW / 32; w++) bt.u[w*32 +: 32] = $urandom;
          bt.s = $urandom;
          bt.l = (b == len - 1);
          if (kind == 3) bt.u[23:16] = 8'hFF;
          stim[i][nb[i]] = bt;
          nb[i]++;
        end
        np[i]++;
      end
    end
  endtask

  // Packet-level round robin: starting after input N-1, repeatedly take the
  // next input (cyclically) that still has packets and emit its whole packet.
  task automatic build_model();
    int    nxt [N];
    int    last;
    int    pick;
    bit    found;
    beat_t e;
    exp_q.delete();
    exp_g.delete();
    for (int i = 0; i < N; i++) nxt[i] = 0;
    last = N - 1;
    forever begin
      found = 1'b0;
      pick  = 0;
      for (int k = 1; k <= N; k++) begin
        if (!found && nxt[(last + k) % N] < np[(last + k) % N]) begin
          found = 1'b1;
          pick  = (last + k) % N;
        end
      end
      if (!found) break;
      for (int b = 0; b < pk_len[pick][nxt[pick]]; b++) begin
        e   = stim[pick][pk_start[pick][nxt[pick]] + b];
        e.u = exp_user(e.u, pick);
        exp_q.push_back(e);
      end
      exp_g.push_back(pick);
      nxt[pick]++;
      last = pick;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    s_tvalid = '0;
    s_tlast  = '0;
    m_tready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------- scenario driver
  task automatic run_scenario(input int kind, input bit stall_en, input bit drop_en);
    bit    vld [N];
    bit    done;
    bit    pend_idle;
    bit    first;
    beat_t cur;
    do_reset();
    gen(kind);
    build_model();
    t_in      = -1;
    t_out     = -1;
    done      = 1'b0;
    pend_idle = 1'b0;
    run_sb    = 1'b1;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (ptr[i] < nb[i]) begin
          cur   = stim[i][ptr[i]];
          first = (ptr[i] == 0) || stim[i][ptr[i] - 1].l;
          vld[i] = first || !drop_en || ($urandom_range(0, 3) != 0);
        end else begin
          cur    = '0;
          vld[i] = 1'b0;
        end
        s_tdata[i*DW +: DW] = cur.d;
        s_tstrb[i*SW +: SW] = cur.s;
        s_tuser[i*UW +: UW] = cur.u;
        s_tlast[i]          = cur.l;
        s_tvalid[i]         = vld[i];
      end
      m_tready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      #4;
      if (pend_idle) begin
        chk("idle_gap_busy", busy, 0);
        chk("idle_gap_ready", s_tready, 0);
        pend_idle = 1'b0;
      end
      chk("ready_onehot", ($countones(s_tready) <= 1), 1);
      if (t_in < 0 && s_tvalid != 0) t_in = cyc;
      for (int i = 0; i < N; i++) begin
        if (vld[i] && s_tready[i]) begin
          if (stim[i][ptr[i]].l) pend_idle = 1'b1;
          ptr[i]++;
        end
      end
      done = (exp_q.size() == 0) && !m_tvalid;
      for (int i = 0; i < N; i++) if (ptr[i] != nb[i]) done = 1'b0;
    end
    if (!done) begin
      n_chk++;
      n_err++;
      $display("FAIL scenario_timeout: kind %0d left %0d beats expected 0", kind, exp_q.size());
    end
    @(negedge clk);
    run_sb = 1'b0;
    chk("grants_consumed", exp_g.size(), 0);
    if (kind == 0) chk("first_beat_latency", t_out - t_in, 2);
    s_tvalid = '0;
  endtask

  // ---------------------------------------------------------------- monitor
  initial begin : monitor
    beat_t e;
    beat_t held;
    bit    held_v;
    bit    prev_busy;
    held_v    = 1'b0;
    prev_busy = 1'b0;
    held      = '0;
    forever begin
      @(negedge clk);
      #4;
      if (run_sb) begin
        if (m_tvalid && t_out < 0) t_out = cyc;
        if (held_v) begin
          chk("stall_valid_hold", m_tvalid, 1);
          chk("stall_data_hold", m_tdata, held.d);
          chk("stall_user_hold", m_tuser, held.u);
        end
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_beat: got data %0h expected no beat", m_tdata);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", m_tdata, e.d);
            chk("beat_strb", m_tstrb, e.s);
            chk("beat_user", m_tuser, e.u);
            chk("beat_last", m_tlast, e.l);
          end
        end
        held_v = m_tvalid && !m_tready;
        held.d = m_tdata;
        held.u = m_tuser;
        if (busy && !prev_busy) begin
          if (exp_g.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_grant: got %0d expected none", grant_idx);
          end else begin
            chk("grant_order", grant_idx, exp_g.pop_front());
          end
        end
        prev_busy = busy;
      end else begin
        held_v    = 1'b0;
        prev_busy = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- reset mid-packet
  task automatic reset_mid_packet();
    int fires;
    do_reset();
    m_tready = 1'b1;
    // Single-beat packet from input 0 moves the round-robin pointer to 0.
    fires = 0;
    for (int c = 0; c < 10 && fires < 1; c++) begin
      @(negedge clk);
      s_tvalid = 4'b0001;
      s_tlast  = 4'b0001;
      s_tdata[0 +: DW] = 256'hA5;
      #4;
      if (s_tready[0]) fires++;
    end
    chk("rst_pre_single_beat", fires, 1);
    @(negedge clk);
    s_tvalid = '0;
    s_tlast  = '0;
    // Input 1 starts a 5-beat packet; reset lands after its second beat.
    fires = 0;
    for (int c = 0; c < 20 && fires < 2; c++) begin
      @(negedge clk);
      s_tvalid = 4'b0010;
      s_tdata[DW +: DW] = 256'(fires + 1);
      #4;
      if (s_tready[1]) fires++;
    end
    chk("rst_two_beats_in", fires, 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #4;
    chk("rst_mid_tvalid", m_tvalid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ready", s_tready, 0);
    chk("rst_mid_grant", grant_idx, 0);
    rst      = 1'b0;
    s_tvalid = 4'b0101;
    @(negedge clk);
    #4;
    chk("rst_regrant_busy", busy, 1);
    chk("rst_regrant_idx", grant_idx, 0);
    s_tvalid = '0;
    do_reset();
  endtask

  // ---------------------------------------------------------------- main
  initial begin : main
    rst      = 1'b1;
    s_tdata  = '0;
    s_tstrb  = '0;
    s_tuser  = '0;
    s_tvalid = '0;
    s_tlast  = '0;
    m_tready = 1'b0;
    repeat (3) @(negedge clk);
    #4;
    chk("reset_m_tvalid", m_tvalid, 0);
    chk("reset_m_tlast", m_tlast, 0);
    chk("reset_m_tdata", m_tdata, 0);
    chk("reset_m_tstrb", m_tstrb, 0);
    chk("reset_m_tuser", m_tuser, 0);
    chk("reset_s_tready", s_tready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_grant_idx", grant_idx, 0);
    rst = 1'b0;

    run_scenario(0, 1'b0, 1'b0);
    run_scenario(1, 1'b0, 1'b0);
    run_scenario(3, 1'b1, 1'b0);
    for (int r = 0; r < 6; r++) run_scenario(2, 1'b1, 1'b1);
    run_scenario(2, 1'b0, 1'b0);
    run_scenario(1, 1'b1, 1'b1);
    reset_mid_packet();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire
